// File: rtl/uart_tx_frame_gen_if.sv
// Word handshake between the TX FIFO read side and the UART frame generator.
// The master offers P_DATA with DATA_VALID; the slave accepts when DATA_READY is high.
interface uart_tx_frame_gen_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  DATA_READY;

    modport master (
        output P_DATA,
        output DATA_VALID,
        input  DATA_READY
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        output DATA_READY
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// Parametrised UART transmitter with a one-word holding register, internal baud prescaler,
// four parity modes and 1/2 stop bits; back-to-back words leave no idle gap on the line.
module uart_tx_frame_gen #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    uart_tx_frame_gen_if.slave        data_if,
    input  logic                      PAR_EN,
    input  logic [1:0]                PAR_MODE,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      BUSY,
    output logic                      FRAME_DONE
);

    localparam int unsigned IdxWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_e;

    state_e                    state_q;
    logic [DATA_WIDTH-1:0]     hold_q;
    logic                      hold_full_q;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic                      par_bit_q;
    logic                      par_en_q;
    logic                      stop2_q;
    logic [PRESCALE_WIDTH-1:0] period_q;
    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [IdxWidth-1:0]       idx_q;
    logic                      tx_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      bit_end;
    logic                      frame_end;
    logic                      start_frame;
    logic                      accept;
    logic                      last_idx;
    logic                      par_in;
    logic [PRESCALE_WIDTH-1:0] period_in;
    logic [DATA_WIDTH-1:0]     shift_next;

    always_comb begin
        bit_end     = (cnt_q == period_q - PRESCALE_WIDTH'(1));
        frame_end   = bit_end & (((state_q == StStop1) & ~stop2_q) | (state_q == StStop2));
        // A pending word starts straight out of idle or off the final stop bit.
        start_frame = hold_full_q & ((state_q == StIdle) | frame_end);
        accept      = data_if.DATA_VALID & ~hold_full_q;
        last_idx    = (idx_q == IdxWidth'(DATA_WIDTH - 1));
        period_in   = (PRESCALE == '0) ? PRESCALE_WIDTH'(1) : PRESCALE;
        shift_next  = shift_q >> 1;
        par_in      = 1'b0;
        unique case (PAR_MODE)
            2'b00: par_in = ^hold_q;
            2'b01: par_in = ~^hold_q;
            2'b10: par_in = 1'b1;
            2'b11: par_in = 1'b0;
        endcase
    end

    assign data_if.DATA_READY = ~hold_full_q;
    assign TX_OUT             = tx_q;
    assign BUSY               = busy_q;
    assign FRAME_DONE         = done_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            stop2_q     <= 1'b0;
            period_q    <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= frame_end;

            if (accept) begin
                hold_q      <= data_if.P_DATA;
                hold_full_q <= 1'b1;
            end else if (start_frame) begin
                hold_full_q <= 1'b0;
            end

            cnt_q <= (state_q == StIdle || bit_end) ? '0 : cnt_q + PRESCALE_WIDTH'(1);

            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        idx_q   <= '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (!last_idx) begin
                            idx_q   <= idx_q + IdxWidth'(1);
                            shift_q <= shift_next;
                            tx_q    <= shift_next[0];
                        end else if (par_en_q) begin
                            state_q <= StParity;
                            tx_q    <= par_bit_q;
                        end else begin
                            state_q <= StStop1;
                            tx_q    <= 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop1;
                        tx_q    <= 1'b1;
                    end
                end
                StStop1: begin
                    if (bit_end) begin
                        if (stop2_q) begin
                            state_q <= StStop2;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                StStop2: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase

            // Overrides the idle/stop transitions above when a word is waiting.
            if (start_frame) begin
                state_q   <= StStart;
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                cnt_q     <= '0;
                shift_q   <= hold_q;
                par_bit_q <= par_in;
                par_en_q  <= PAR_EN;
                stop2_q   <= STOP2;
                period_q  <= period_in;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: words are pushed to a scoreboard on accept and a
// line monitor checks every serial cycle, BUSY and FRAME_DONE against a reference frame.
module tb_uart_tx_frame_gen;

    typedef struct {
        logic [7:0]  data;
        int unsigned p;
        bit          par_en;
        logic [1:0]  mode;
        bit          stop2;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       par_en;
    logic [1:0] par_mode;
    logic       stop2;
    logic [7:0] prescale;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         n_frames = 0;
    int         done_cnt = 0;
    bit         mon_en   = 1'b1;
    frame_t     sb[$];

    uart_tx_frame_gen_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_gen #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(8)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .data_if   (bus),
        .PAR_EN    (par_en),
        .PAR_MODE  (par_mode),
        .STOP2     (stop2),
        .PRESCALE  (prescale),
        .TX_OUT    (tx_out),
        .BUSY      (busy),
        .FRAME_DONE(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] d, input logic [1:0] m);
        logic ones;
        ones = 1'b0;
        for (int i = 0; i < 8; i++) ones = ones ^ d[i];
        if (m == 2'b00) return ones;
        if (m == 2'b01) return ~ones;
        return (m == 2'b10);
    endfunction

    // Offer a word (called at a negedge), wait for the accept edge, optionally log it.
    task automatic send(input logic [7:0] d, input bit push);
        int     n;
        frame_t e;
        bus.P_DATA     = d;
        bus.DATA_VALID = 1'b1;
        n = 0;
        while (bus.DATA_READY !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 1000, 1);
        @(posedge clk);
        if (push) begin
            e.data   = d;
            e.p      = (prescale == 0) ? 1 : prescale;
            e.par_en = par_en;
            e.mode   = par_mode;
            e.stop2  = stop2;
            sb.push_back(e);
            n_frames++;
        end
        @(negedge clk);
        check("ready_drop", bus.DATA_READY, 0);
        bus.DATA_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy === 1'b0 && bus.DATA_READY === 1'b1 && sb.size() == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", n < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    // Line monitor: checks each frame cycle-by-cycle against the scoreboard head.
    initial begin : monitor
        bit     pend;
        bit     first;
        frame_t e;
        logic   bits[$];
        pend = 1'b0;
        forever begin
            if (!pend) @(negedge clk);
            pend = 1'b0;
            if (mon_en && rst === 1'b0 && tx_out === 1'b0) begin
                check("sb_has_frame", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    bits.delete();
                    bits.push_back(1'b0);
                    for (int i = 0; i < 8; i++) bits.push_back(e.data[i]);
                    if (e.par_en) bits.push_back(model_parity(e.data, e.mode));
                    bits.push_back(1'b1);
                    if (e.stop2) bits.push_back(1'b1);
                    first = 1'b1;
                    foreach (bits[i]) begin
                        for (int unsigned c = 0; c < e.p; c++) begin
                            if (!first) @(negedge clk);
                            check("tx_bit", tx_out, bits[i]);
                            check("busy_in_frame", busy, 1);
                            if (!first) check("done_mid", frame_done, 0);
                            first = 1'b0;
                        end
                    end
                    @(negedge clk);
                    check("frame_done", frame_done, 1);
                    check("busy_after", busy, sb.size() != 0);
                    check("line_after", tx_out, sb.size() == 0);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : stim
        int n;
        rst            = 1'b1;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA     = 8'h00;
        par_en         = 1'b0;
        par_mode       = 2'b00;
        stop2          = 1'b0;
        prescale       = 8'd4;
        repeat (3) @(negedge clk);
        // A handshake during reset must be dropped.
        bus.P_DATA     = 8'hFF;
        bus.DATA_VALID = 1'b1;
        @(negedge clk);
        bus.DATA_VALID = 1'b0;
        rst            = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx", tx_out, 1);
            check("idle_busy", busy, 0);
            check("idle_done", frame_done, 0);
            check("idle_ready", bus.DATA_READY, 1);
        end

        // Basic 8N1 frame, P=4.
        send(8'hA5, 1'b1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else if (n > 0) break;
        end
        check("busy_len", n, 40);
        wait_idle();

        // Parity modes at P=1, then even parity with two stop bits.
        prescale = 8'd1;
        par_en   = 1'b1;
        for (int m = 0; m < 4; m++) begin
            par_mode = 2'(m);
            send(8'h03, 1'b1);
            wait_idle();
        end
        par_mode = 2'b00;
        stop2    = 1'b1;
        send(8'h03, 1'b1);
        wait_idle();

        // Back-to-back words at P=2.
        par_en   = 1'b0;
        stop2    = 1'b0;
        prescale = 8'd2;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        wait_idle();

        // PRESCALE change during DATA only affects the following frame.
        prescale = 8'd4;
        send(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        prescale = 8'd8;
        send(8'hC3, 1'b1);
        wait_idle();

        // PRESCALE=0 behaves as 1, with odd parity.
        prescale = 8'd0;
        par_en   = 1'b1;
        par_mode = 2'b01;
        send(8'h5A, 1'b1);
        wait_idle();

        // Reset during data bit 3 with the holding register full.
        par_en   = 1'b0;
        prescale = 8'd4;
        mon_en   = 1'b0;
        send(8'hC3, 1'b0);
        send(8'h81, 1'b0);
        repeat (16) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_hold_empty", bus.DATA_READY, 1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_tx", tx_out, 1);
            check("post_rst_busy", busy, 0);
            check("post_rst_done", frame_done, 0);
        end
        mon_en = 1'b1;
        send(8'h96, 1'b1);
        wait_idle();

        check("done_count", done_cnt, n_frames);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
